// File: rtl/mvau_fold_sched_pkg.sv
// Shared definitions for the MVAU activation-reuse scheduler:
// fold derivation helpers and the scheduler state encoding.
package mvau_defn;

    typedef enum logic {
        FILL  = 1'b0,
        REUSE = 1'b1
    } sched_state_e;

    // Synapse folds: beats per input vector.
    function automatic int unsigned calc_sf(input int unsigned matrix_w, input int unsigned simd);
        return matrix_w / simd;
    endfunction

    // Neuron folds: number of times each vector is replayed.
    function automatic int unsigned calc_nf(input int unsigned matrix_h, input int unsigned pe);
        return matrix_h / pe;
    endfunction

    // Counter width for a 0..n-1 counter, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvau_fold_sched_if.sv
// Upstream activation stream plus downstream beat/sideband bundle
// for mvau_fold_sched. The DUT uses the slave modport.
interface mvau_fold_sched_if #(
    parameter int unsigned ACT_W   = 8,
    parameter int unsigned WADDR_W = 6
);
    logic               in_v;
    logic               in_rdy;
    logic [ACT_W-1:0]   in_act;
    logic               out_v;
    logic               out_rdy;
    logic [ACT_W-1:0]   out_act;
    logic [WADDR_W-1:0] wgt_addr;
    logic               sf_last;
    logic               nf_last;
    logic [31:0]        vec_cnt;

    modport slave (
        input  in_v, in_act, out_rdy,
        output in_rdy, out_v, out_act, wgt_addr, sf_last, nf_last, vec_cnt
    );

    modport master (
        output in_v, in_act, out_rdy,
        input  in_rdy, out_v, out_act, wgt_addr, sf_last, nf_last, vec_cnt
    );
endinterface

// File: rtl/mvau_fold_sched_act_buf.sv
// mvau_act_buf: SF-deep activation buffer, one synchronous write port and
// one asynchronous read port. Contents are not reset.
module mvau_act_buf #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Capture the accepted beat at its synapse-fold slot.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/mvau_fold_sched.sv
// mvau_fold_sched: accepts each activation vector once (SF beats), replays
// it NF times with matching weight address and fold-boundary flags.
// Optional: define MVAU_FOLD_SCHED_STATS_EN to count completed vectors.
module mvau_fold_sched
    import mvau_defn::*;
#(
    parameter int unsigned MatrixW = 16,
    parameter int unsigned MatrixH = 16,
    parameter int unsigned SIMD    = 2,
    parameter int unsigned PE      = 2,
    parameter int unsigned TSrcI   = 4,
    parameter int unsigned WADDR_W = $clog2(MatrixW / SIMD * MatrixH / PE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mvau_fold_sched_if.slave       bus
);
    localparam int unsigned SF    = calc_sf(MatrixW, SIMD);
    localparam int unsigned NF    = calc_nf(MatrixH, PE);
    localparam int unsigned SF_W  = cnt_w(SF);
    localparam int unsigned NF_W  = cnt_w(NF);
    localparam int unsigned ACT_W = SIMD * TSrcI;

    sched_state_e       state_q, state_d;
    logic [SF_W-1:0]    sf_q, sf_d;
    logic [NF_W-1:0]    nf_q, nf_d;
    logic               out_v_q, out_v_d;
    logic [ACT_W-1:0]   out_act_q, out_act_d;
    logic [WADDR_W-1:0] wgt_addr_q, wgt_addr_d;
    logic               sf_last_q, sf_last_d;
    logic               nf_last_q, nf_last_d;

    logic               drain_ok;
    logic               in_rdy;
    logic               load;
    logic               buf_we;
    logic               at_sf_last;
    logic               at_nf_last;
    logic [ACT_W-1:0]   buf_rdata;
    logic [ACT_W-1:0]   load_act;

    mvau_act_buf #(
        .DEPTH (SF),
        .WIDTH (ACT_W),
        .AW    (SF_W)
    ) u_act_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (sf_q),
        .wdata (bus.in_act),
        .raddr (sf_q),
        .rdata (buf_rdata)
    );

    // Handshake decode: output slot free, upstream ready only while filling.
    always_comb begin
        drain_ok   = !out_v_q || bus.out_rdy;
        in_rdy     = rst_n && (state_q == FILL) && drain_ok;
        load       = (state_q == FILL) ? (bus.in_v && in_rdy) : drain_ok;
        buf_we     = (state_q == FILL) && load;
        load_act   = (state_q == FILL) ? bus.in_act : buf_rdata;
        at_sf_last = (sf_q == SF_W'(SF - 1));
        at_nf_last = (nf_q == NF_W'(NF - 1));
    end

    // Next-state: output register, sideband, fold counters and FSM advance per load.
    always_comb begin
        state_d    = state_q;
        sf_d       = sf_q;
        nf_d       = nf_q;
        out_v_d    = out_v_q;
        out_act_d  = out_act_q;
        wgt_addr_d = wgt_addr_q;
        sf_last_d  = sf_last_q;
        nf_last_d  = nf_last_q;
        if (drain_ok) out_v_d = load;
        if (load) begin
            out_act_d  = load_act;
            wgt_addr_d = WADDR_W'(nf_q) * WADDR_W'(SF) + WADDR_W'(sf_q);
            sf_last_d  = at_sf_last;
            nf_last_d  = at_nf_last;
            if (at_sf_last) begin
                sf_d = '0;
                if (at_nf_last) begin
                    nf_d    = '0;
                    state_d = FILL;
                end else begin
                    nf_d    = nf_q + NF_W'(1);
                    state_d = REUSE;
                end
            end else begin
                sf_d = sf_q + SF_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            sf_q       <= '0;
            nf_q       <= '0;
            out_v_q    <= 1'b0;
            out_act_q  <= '0;
            wgt_addr_q <= '0;
            sf_last_q  <= 1'b0;
            nf_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sf_q       <= sf_d;
            nf_q       <= nf_d;
            out_v_q    <= out_v_d;
            out_act_q  <= out_act_d;
            wgt_addr_q <= wgt_addr_d;
            sf_last_q  <= sf_last_d;
            nf_last_q  <= nf_last_d;
        end
    end

`ifdef MVAU_FOLD_SCHED_STATS_EN
    logic [31:0] vec_cnt_q, vec_cnt_d;

    // Count vectors as their final beat is loaded.
    always_comb begin
        vec_cnt_d = vec_cnt_q;
        if (load && at_sf_last && at_nf_last) vec_cnt_d = vec_cnt_q + 32'd1;
    end

    // Completed-vector counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vec_cnt_q <= '0;
        else        vec_cnt_q <= vec_cnt_d;
    end

    assign bus.vec_cnt = vec_cnt_q;
`else
    assign bus.vec_cnt = '0;
`endif

    assign bus.in_rdy   = in_rdy;
    assign bus.out_v    = out_v_q;
    assign bus.out_act  = out_act_q;
    assign bus.wgt_addr = wgt_addr_q;
    assign bus.sf_last  = sf_last_q;
    assign bus.nf_last  = nf_last_q;
endmodule

// File: tb/tb_mvau_fold_sched.sv
// Scoreboard bench for mvau_fold_sched: SF=2/NF=3 instance plus an NF=1 instance.
module tb_mvau_fold_sched;

    typedef struct packed {
        logic [7:0] act;
        logic [2:0] addr;
        logic       sf_last;
        logic       nf_last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int rdy_low_cnt = 0;
    int run_len = 0;
    int best_run = 0;
    int popped_a = 0;

    exp_t qa[$];
    exp_t qb[$];
    bit   b_active = 1'b0;

    mvau_fold_sched_if #(.ACT_W(8), .WADDR_W(3)) busa ();
    mvau_fold_sched_if #(.ACT_W(8), .WADDR_W(1)) busb ();

    mvau_fold_sched #(
        .MatrixW (4), .MatrixH (6), .SIMD (2), .PE (2), .TSrcI (4), .WADDR_W (3)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busa)
    );

    mvau_fold_sched #(
        .MatrixW (4), .MatrixH (2), .SIMD (2), .PE (2), .TSrcI (4), .WADDR_W (1)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busb)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    // Expected beats for one vector on the NF=3 instance.
    task automatic push_vec(input logic [7:0] a0, input logic [7:0] a1);
        exp_t e;
        for (int nf = 0; nf < 3; nf++) begin
            for (int sf = 0; sf < 2; sf++) begin
                e.act     = (sf == 1) ? a1 : a0;
                e.addr    = 3'(nf * 2 + sf);
                e.sf_last = (sf == 1);
                e.nf_last = (nf == 2);
                qa.push_back(e);
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_a(input logic [7:0] a);
        bit ok = 1'b0;
        busa.in_v   = 1'b1;
        busa.in_act = a;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = busa.in_rdy;
            @(posedge clk);
            #1;
        end
        busa.in_v = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL a_send_timeout: act 0x%0h never accepted", a);
        end
    endtask

    task automatic send_b(input logic [7:0] a);
        bit ok = 1'b0;
        busb.in_v   = 1'b1;
        busb.in_act = a;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = busb.in_rdy;
            @(posedge clk);
            #1;
        end
        busb.in_v = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL b_send_timeout: act 0x%0h never accepted", a);
        end
    endtask

    task automatic drain_a();
        int n = 0;
        while (qa.size() != 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("a_drain_left", 32'(qa.size()), 32'd0);
    endtask

    task automatic drain_b();
        int n = 0;
        while (qb.size() != 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("b_drain_left", 32'(qb.size()), 32'd0);
    endtask

    // Monitor for the NF=3 instance: compare every presented beat, pop on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (!busa.in_rdy) rdy_low_cnt++;
            if (busa.out_v) begin
                run_len++;
                if (run_len > best_run) best_run = run_len;
            end else begin
                run_len = 0;
            end
            if (busa.out_v) begin
                if (qa.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL a_unexpected_beat: got act=0x%0h addr=%0d, required no beat",
                             busa.out_act, busa.wgt_addr);
                end else begin
                    e = qa[0];
                    tests++;
                    if ({busa.out_act, busa.wgt_addr, busa.sf_last, busa.nf_last} !== e) begin
                        fails++;
                        $display("FAIL a_beat: got act=0x%0h addr=%0d sfl=%0b nfl=%0b, required act=0x%0h addr=%0d sfl=%0b nfl=%0b",
                                 busa.out_act, busa.wgt_addr, busa.sf_last, busa.nf_last,
                                 e.act, e.addr, e.sf_last, e.nf_last);
                    end
                    if (busa.out_rdy) begin
                        void'(qa.pop_front());
                        popped_a++;
                    end
                end
            end
        end
    end

    // Monitor for the NF=1 instance, including the pass-through ready rule.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b_active) begin
            chk("b_in_rdy", 32'(busb.in_rdy), 32'(!busb.out_v || busb.out_rdy));
            if (busb.out_v) begin
                if (qb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_unexpected_beat: got act=0x%0h, required no beat", busb.out_act);
                end else begin
                    e = qb[0];
                    tests++;
                    if ({busb.out_act, 2'b00, busb.wgt_addr, busb.sf_last, busb.nf_last} !== e) begin
                        fails++;
                        $display("FAIL b_beat: got act=0x%0h addr=%0d sfl=%0b nfl=%0b, required act=0x%0h addr=%0d sfl=%0b nfl=%0b",
                                 busb.out_act, busb.wgt_addr, busb.sf_last, busb.nf_last,
                                 e.act, e.addr, e.sf_last, e.nf_last);
                    end
                    if (busb.out_rdy) void'(qb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [3:0] pat;
        logic [31:0] vec_req;
        exp_t eb;

        busa.in_v = 1'b0; busa.in_act = '0; busa.out_rdy = 1'b1;
        busb.in_v = 1'b0; busb.in_act = '0; busb.out_rdy = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_rdy", 32'(busa.in_rdy), 32'd0);
        chk("rst_outputs", {busa.out_v, busa.out_act, busa.wgt_addr, busa.sf_last, busa.nf_last}, 32'd0);
        chk("rst_vec_cnt", busa.vec_cnt, 32'd0);
        #2 rst_n = 1'b1;
        #1 chk("rel_in_rdy", 32'(busa.in_rdy), 32'd1);
        @(posedge clk); #1;

        // Single vector, in_rdy low for the four reuse beats
        rdy_low_cnt = 0;
        push_vec(8'h21, 8'h43);
        send_a(8'h21);
        send_a(8'h43);
        drain_a();
        repeat (3) @(posedge clk);
        #1 chk("a_rdy_low_cycles", 32'(rdy_low_cnt), 32'd4);

        // Back-to-back vectors with in_v held high: 12-beat unbroken run
        best_run = 0;
        push_vec(8'h21, 8'h43);
        push_vec(8'h65, 8'h87);
        send_a(8'h21); busa.in_v = 1'b1;
        send_a(8'h43); busa.in_v = 1'b1;
        send_a(8'h65); busa.in_v = 1'b1;
        send_a(8'h87);
        drain_a();
        repeat (2) @(posedge clk);
        #1 chk("a_b2b_run", 32'(best_run), 32'd12);

        // Stall during reuse with out_rdy 1,0,0,1
        push_vec(8'hA9, 8'hCB);
        send_a(8'hA9);
        send_a(8'hCB);
        pat = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            busa.out_rdy = pat[i];
            @(posedge clk); #1;
        end
        busa.out_rdy = 1'b1;
        drain_a();

        // Reset after three output beats
        push_vec(8'h12, 8'h34);
        popped_a = 0;
        send_a(8'h12);
        send_a(8'h34);
        for (int n = 0; n < 20 && popped_a < 3; n++) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", {busa.out_v, busa.out_act, busa.wgt_addr, busa.sf_last, busa.nf_last}, 32'd0);
        chk("mid_rst_in_rdy", 32'(busa.in_rdy), 32'd0);
        chk("mid_rst_vec_cnt", busa.vec_cnt, 32'd0);
        qa.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Fresh vector after reset, then four more for the statistics count
        push_vec(8'h65, 8'h87);
        send_a(8'h65);
        send_a(8'h87);
        drain_a();
        push_vec(8'h01, 8'h02);
        send_a(8'h01); send_a(8'h02);
        push_vec(8'hF0, 8'h0F);
        send_a(8'hF0); send_a(8'h0F);
        push_vec(8'h5A, 8'hA5);
        send_a(8'h5A); send_a(8'hA5);
        push_vec(8'hFF, 8'h00);
        send_a(8'hFF); send_a(8'h00);
        drain_a();
        repeat (2) @(posedge clk);
`ifdef MVAU_FOLD_SCHED_STATS_EN
        vec_req = 32'd5;
`else
        vec_req = 32'd0;
`endif
        #1 chk("a_vec_cnt", busa.vec_cnt, vec_req);

        // NF=1 pass-through
        b_active = 1'b1;
        eb = '{act: 8'h11, addr: 3'd0, sf_last: 1'b0, nf_last: 1'b1}; qb.push_back(eb);
        eb = '{act: 8'h22, addr: 3'd1, sf_last: 1'b1, nf_last: 1'b1}; qb.push_back(eb);
        eb = '{act: 8'h33, addr: 3'd0, sf_last: 1'b0, nf_last: 1'b1}; qb.push_back(eb);
        eb = '{act: 8'h44, addr: 3'd1, sf_last: 1'b1, nf_last: 1'b1}; qb.push_back(eb);
        send_b(8'h11);
        chk("b_latency_0", {23'd0, busb.out_v, busb.out_act}, {23'd0, 1'b1, 8'h11});
        send_b(8'h22);
        chk("b_latency_1", {23'd0, busb.out_v, busb.out_act}, {23'd0, 1'b1, 8'h22});
        busb.out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 busb.out_rdy = 1'b1;
        send_b(8'h33);
        send_b(8'h44);
        drain_b();
        repeat (2) @(posedge clk);
        b_active = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
